// File: rtl/ps2_keyboard_receiver_if.sv
// PS/2 keyboard link: open-collector clock and data from the keyboard.
interface ps2_keyboard_receiver_if;
    logic keyb_clk;
    logic kdata;

    modport master (output keyb_clk, output kdata);
    modport slave  (input  keyb_clk, input  kdata);
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, tracks make/break
// scan codes and keeps held-key state for two players' five controls.
module ps2_keyboard_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_keyboard_receiver_if.slave  ps2,
    output logic [4:0]              p1keys,
    output logic [4:0]              p2keys,
    output logic [7:0]              debugLEDs
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_stop_seen;

    logic        r_clk_s1, r_clk_s2, r_clk_prev;
    logic        r_dat_s1, r_dat_s2;
    logic        w_fall;

    logic [CW-1:0] r_idle_cnt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [7:0]  r_byte;
    logic        r_byte_vld;
    logic        r_byte_err;

    logic        r_brk;
    logic        r_ext;
    logic [9:0]  r_keys;
    logic [7:0]  r_leds;
    logic [9:0]  w_mask;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign p1keys    = r_keys[4:0];
    assign p2keys    = r_keys[9:5];
    assign debugLEDs = r_leds;

    // Two-flop synchronisers for the asynchronous PS/2 lines plus edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2.keyb_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2.kdata;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame sequencing on keyboard clock falls; idle timeout drops partial frames
    always_comb begin
        w_state_nxt = r_state;
        w_stop_seen = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_START:  if (!r_dat_s2) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_START;
                    w_stop_seen = 1'b1;
                end
                default:   w_state_nxt = ST_START;
            endcase
        end else if (r_state != ST_START && r_idle_cnt >= TO_VAL) begin
            w_state_nxt = ST_START;
        end
    end

    // Bit capture, idle counter and end-of-frame validity check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_byte_err <= 1'b0;
        end else begin
            if (w_fall) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != TO_VAL) begin
                r_idle_cnt <= r_idle_cnt + CW'(1);
            end

            if (w_fall) begin
                case (r_state)
                    ST_START:  r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= r_dat_s2;
                    default:   ;
                endcase
            end

            r_byte_vld <= 1'b0;
            r_byte_err <= 1'b0;
            if (w_stop_seen) begin
                if (r_dat_s2 && (^{r_parity, r_shift})) begin
                    r_byte     <= r_shift;
                    r_byte_vld <= 1'b1;
                end else begin
                    r_byte_err <= 1'b1;
                end
            end
        end
    end

    // Scan code to key bit: [4:0] player 1, [9:5] player 2; extended prefix ignored
    always_comb begin
        w_mask = '0;
        case (r_byte)
            8'h1D: w_mask[0] = 1'b1;
            8'h1B: w_mask[1] = 1'b1;
            8'h1C: w_mask[2] = 1'b1;
            8'h23: w_mask[3] = 1'b1;
            8'h29: w_mask[4] = 1'b1;
            8'h75: w_mask[5] = 1'b1;
            8'h72: w_mask[6] = 1'b1;
            8'h6B: w_mask[7] = 1'b1;
            8'h74: w_mask[8] = 1'b1;
            8'h5A: w_mask[9] = 1'b1;
            default: w_mask = '0;
        endcase
    end

    // Make/break decode of each accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys <= '0;
            r_leds <= '0;
            r_brk  <= 1'b0;
            r_ext  <= 1'b0;
        end else if (r_byte_vld) begin
            r_leds <= r_byte;
            if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                if (r_brk) begin
                    r_keys <= r_keys & ~w_mask;
                end else begin
                    r_keys <= r_keys | w_mask;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end else if (r_byte_err && (r_brk || r_ext)) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for the PS/2 keyboard receiver against a scan-code model.
module tb_ps2_keyboard_receiver;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 10;

    localparam logic [7:0] P1C [5] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
    localparam logic [7:0] P2C [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] p1keys;
    logic [4:0] p2keys;
    logic [7:0] debugLEDs;

    ps2_keyboard_receiver_if ps2_bus ();

    ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2       (ps2_bus.slave),
        .p1keys    (p1keys),
        .p2keys    (p2keys),
        .debugLEDs (debugLEDs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] m_p1;
    logic [4:0] m_p2;
    logic [7:0] m_leds;
    bit         m_brk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_bus.kdata = b;
        wait_clks(HALF);
        ps2_bus.keyb_clk = 1'b0;
        wait_clks(HALF);
        ps2_bus.keyb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = code;
        f[9]   = (~^code) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_bus.kdata = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_leds = '0; m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] code, input bit ok);
        if (!ok) begin
            m_brk = 1'b0;
        end else begin
            m_leds = code;
            if (code == 8'hF0) begin
                m_brk = 1'b1;
            end else if (code != 8'hE0) begin
                for (int k = 0; k < 5; k++) begin
                    if (code == P1C[k]) m_p1[k] = !m_brk;
                    if (code == P2C[k]) m_p2[k] = !m_brk;
                end
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_p1"},  {27'd0, p1keys},    {27'd0, m_p1});
        check_eq({tag, "_p2"},  {27'd0, p2keys},    {27'd0, m_p2});
        check_eq({tag, "_led"}, {24'd0, debugLEDs}, {24'd0, m_leds});
    endtask

    task automatic xfer(input logic [7:0] code, input bit bad_par, input bit bad_stop, input string tag);
        send_frame(code, bad_par, bad_stop, 11);
        model_byte(code, !(bad_par || bad_stop));
        check_model(tag);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] code;
        int         r;
        bit         bp, bs;

        ps2_bus.keyb_clk = 1'b1;
        ps2_bus.kdata    = 1'b1;
        model_reset();
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2);
        check_model("reset");

        xfer(8'h75, 0, 0, "make75");
        check_eq("make75_p2_const", {27'd0, p2keys}, 32'h01);
        xfer(8'hF0, 0, 0, "brk_f0");
        xfer(8'h75, 0, 0, "brk75");
        check_eq("brk75_led_const", {24'd0, debugLEDs}, 32'h75);

        xfer(8'h1D, 0, 0, "m1d");
        xfer(8'h29, 0, 0, "m29");
        xfer(8'hE0, 0, 0, "e0");
        xfer(8'h6B, 0, 0, "e06b");
        check_eq("multi_p1_const", {27'd0, p1keys}, 32'h11);
        check_eq("multi_p2_const", {27'd0, p2keys}, 32'h04);
        xfer(8'hF0, 0, 0, "f0b");
        xfer(8'h29, 0, 0, "brk29");
        check_eq("brk29_p1_const", {27'd0, p1keys}, 32'h01);

        xfer(8'h1C, 1, 0, "badpar");
        check_eq("badpar_led_const", {24'd0, debugLEDs}, 32'h29);

        // partial frame abandoned by timeout, then a clean frame
        send_frame(8'h55, 0, 0, 5);
        wait_clks(TO + 10);
        xfer(8'h23, 0, 0, "timeout23");
        check_eq("timeout_p1_3", {31'd0, p1keys[3]}, 32'd1);

        // a lone falling edge with data high is not a start bit
        send_bit(1'b1);
        wait_clks(HALF);
        xfer(8'h1B, 0, 0, "glitch1b");

        xfer(8'h1D, 0, 1, "badstop");

        for (int n = 0; n < 150; n++) begin
            r  = int'($urandom_range(0, 9));
            bp = 1'b0;
            bs = 1'b0;
            if (r <= 5) begin
                r = int'($urandom_range(0, 9));
                code = (r < 5) ? P1C[r] : P2C[r - 5];
            end else if (r == 6) begin
                code = 8'hE0;
            end else if (r == 7) begin
                code = 8'hF0;
            end else begin
                code = 8'($urandom);
                if (r == 9) begin
                    if ($urandom_range(0, 1) == 0) bp = 1'b1; else bs = 1'b1;
                end
            end
            xfer(code, bp, bs, "rand");
        end

        // fill player 1, then reset in the middle of a frame
        for (int k = 0; k < 5; k++) begin
            xfer(8'hF0, 0, 0, "pre_f0");
            xfer(P1C[k], 0, 0, "pre_rel");
            xfer(P1C[k], 0, 0, "hold");
        end
        check_eq("hold_all_const", {27'd0, p1keys}, 32'h1F);
        send_frame(8'h2A, 0, 0, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_model("midrst");
        wait_clks(HALF);
        xfer(8'h1B, 0, 0, "after_rst");
        check_eq("after_rst_p1_const", {27'd0, p1keys}, 32'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
